// File: rtl/vline_pkg.sv
// Shared types and constants for the vertical-line motion controller.
// The coordinate limits describe the external counter that at_max/at_min report on.
package vline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_HOLD
    } state_e;

    localparam int SPEED_W_DEF = 2;
    localparam int COORD_MAX   = 487;
    localparam int COORD_MIN   = 18;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button conditioner: two-flop synchroniser, then a rising-edge detect.
// A button already held when reset releases stays silent until released and pressed again.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic rise
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       last_q, last_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        meta_d  = btn_in;
        sync_d  = meta_q;
        last_d  = sync_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q;
        // sync_q only reflects the pin once the chain has refilled after reset
        if (fill_q[1] && !sync_q) begin
            armed_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            last_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            last_q  <= last_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign rise = sync_q && !last_q && armed_q;

endmodule

// File: rtl/vline_motion_ctrl.sv
// Frame-paced step/load strobe generator for a vertical-line coordinate counter.
// Build option: define VLINE_AUTO_BOUNCE_EN to bounce off a limit instead of holding there.
module vline_motion_ctrl
    import vline_pkg::*;
#(
    parameter int   SPEED_W = SPEED_W_DEF,
    parameter logic DEF_DIR = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic               run,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_ld,
    input  logic [SPEED_W-1:0] speed,
    input  logic               at_max,
    input  logic               at_min,
    output logic               UP,
    output logic               DW,
    output logic               LD,
    output logic               dir,
    output logic               moving
);

    // Wide enough for the longest period, 2^(2^SPEED_W - 1) frames.
    localparam int DIV_W = (1 << SPEED_W) - 1;

    logic inc_ev, dec_ev, ld_ev;

    btn_sync_edge u_sync_inc (.clk(clk), .reset(reset), .btn_in(btn_inc), .rise(inc_ev));
    btn_sync_edge u_sync_dec (.clk(clk), .reset(reset), .btn_in(btn_dec), .rise(dec_ev));
    btn_sync_edge u_sync_ld  (.clk(clk), .reset(reset), .btn_in(btn_ld),  .rise(ld_ev));

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               up_q, up_d;
    logic               dw_q, dw_d;
    logic               ld_q, ld_d;
    logic [DIV_W-1:0]   div_lim;
    logic               one_dir;

    // div_lim = 2^speed - 1, built as a thermometer code of the low bits
    always_comb begin
        div_lim = '0;
        for (int i = 0; i < DIV_W; i++) begin
            div_lim[i] = (i < int'(speed));
        end
    end

    assign one_dir = inc_ev ^ dec_ev;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        div_cnt_d = div_cnt_q;
        up_d      = 1'b0;
        dw_d      = 1'b0;
        ld_d      = 1'b0;

        if (ld_ev) begin
            ld_d    = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run && one_dir) begin
                        state_d   = ST_MOVE;
                        dir_d     = inc_ev;
                        div_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (one_dir && (inc_ev != dir_q)) begin
                        state_d   = ST_MOVE;
                        dir_d     = inc_ev;
                        div_cnt_d = '0;
                    end
                end
                ST_MOVE: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                    end else begin
                        // A reversal in the same cycle as a step steers that step.
                        if (one_dir) begin
                            dir_d = inc_ev;
                        end
                        if (frame) begin
                            if (div_cnt_q >= div_lim) begin
                                if (dir_d ? at_max : at_min) begin
`ifdef VLINE_AUTO_BOUNCE_EN
                                    dir_d = ~dir_d;
`else
                                    state_d = ST_HOLD;
`endif
                                end else begin
                                    up_d      = dir_d;
                                    dw_d      = ~dir_d;
                                    div_cnt_d = '0;
                                end
                            end else begin
                                div_cnt_d = div_cnt_q + DIV_W'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DEF_DIR;
            div_cnt_q <= '0;
            up_q      <= 1'b0;
            dw_q      <= 1'b0;
            ld_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            div_cnt_q <= div_cnt_d;
            up_q      <= up_d;
            dw_q      <= dw_d;
            ld_q      <= ld_d;
        end
    end

    assign UP     = up_q;
    assign DW     = dw_q;
    assign LD     = ld_q;
    assign dir    = dir_q;
    assign moving = (state_q == ST_MOVE);

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Scoreboard bench for vline_motion_ctrl: a behavioural model predicts strobes per clock edge,
// a negedge monitor pops and compares them and also tracks moving/dir.
module tb_vline_motion_ctrl;

    localparam int       SW         = vline_pkg::SPEED_W_DEF;
    localparam logic     TB_DEF_DIR = 1'b0;
    localparam logic [2:0] K_UP = 3'b001;
    localparam logic [2:0] K_DW = 3'b010;
    localparam logic [2:0] K_LD = 3'b100;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_HOLD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame, run, btn_inc, btn_dec, btn_ld, at_max, at_min;
    logic [SW-1:0] speed;
    logic          UP, DW, LD, dir, moving;

    vline_motion_ctrl #(.SPEED_W(SW), .DEF_DIR(TB_DEF_DIR)) dut (
        .clk(clk), .reset(reset), .frame(frame), .run(run),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ld(btn_ld),
        .speed(speed), .at_max(at_max), .at_min(at_min),
        .UP(UP), .DW(DW), .LD(LD), .dir(dir), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    exp_t exp_q[$];
    int   q_inc[$], q_dec[$], q_ld[$];
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   n_up = 0, n_dw = 0, n_ld = 0;

    int   m_mode;
    logic m_dir;
    int   m_frames;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_dir    = TB_DEF_DIR;
        m_frames = 0;
        exp_q.delete();
        q_inc.delete();
        q_dec.delete();
        q_ld.delete();
    endtask

    // Applies the behavioural rules to the inputs sampled at clock edge e.
    task automatic model_edge();
        int   e;
        bit   inc, dec, ld, blocked;
        int   period;
        e   = cyc;
        inc = (q_inc.size() > 0 && q_inc[0] == e);
        dec = (q_dec.size() > 0 && q_dec[0] == e);
        ld  = (q_ld.size()  > 0 && q_ld[0]  == e);
        if (inc) void'(q_inc.pop_front());
        if (dec) void'(q_dec.pop_front());
        if (ld)  void'(q_ld.pop_front());

        if (ld) begin
            exp_q.push_back('{cyc: e, kind: K_LD});
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (run && inc != dec) begin
                m_mode = M_MOVE; m_dir = inc; m_frames = 0;
            end
        end else if (m_mode == M_HOLD) begin
            if (inc != dec && inc != m_dir) begin
                m_mode = M_MOVE; m_dir = inc; m_frames = 0;
            end
        end else if (!run) begin
            m_mode = M_IDLE;
        end else begin
            if (inc != dec) m_dir = inc;
            if (frame) begin
                period = 1 << speed;
                if (m_frames + 1 >= period) begin
                    blocked = m_dir ? at_max : at_min;
                    if (blocked) begin
`ifdef VLINE_AUTO_BOUNCE_EN
                        m_dir = !m_dir;
`else
                        m_mode = M_HOLD;
`endif
                    end else begin
                        exp_q.push_back('{cyc: e, kind: (m_dir ? K_UP : K_DW)});
                        m_frames = 0;
                    end
                end else begin
                    m_frames++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        cyc++;
        #1;
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            0: btn_inc = val;
            1: btn_dec = val;
            default: btn_ld = val;
        endcase
        // a new press first reaches the edge detector two edges after it is sampled
        if (val) begin
            case (which)
                0: q_inc.push_back(cyc + 2);
                1: q_dec.push_back(cyc + 2);
                default: q_ld.push_back(cyc + 2);
            endcase
        end
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) tick();
        case (which)
            0: btn_inc = 1'b0;
            1: btn_dec = 1'b0;
            default: btn_ld = 1'b0;
        endcase
    endtask

    task automatic frame_pulse(input int gap);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        repeat (gap) tick();
    endtask

    // Monitor: pops one expected strobe per edge that carries one and tracks state outputs.
    always @(negedge clk) begin
        logic [2:0] act;
        exp_t       x;
        int         e;
        if (!reset) begin
            act = {LD, DW, UP};
            e   = cyc - 1;
            if (UP) n_up++;
            if (DW) n_dw++;
            if (LD) n_ld++;
            if (exp_q.size() > 0 && exp_q[0].cyc == e) begin
                x = exp_q.pop_front();
                check("strobe", int'(act), int'(x.kind));
            end else if (act != 3'b000) begin
                check("unexpected_strobe", int'(act), 0);
            end
            check("moving", int'(moving), int'(m_mode == M_MOVE));
            check("dir", int'(dir), int'(m_dir));
        end
    end

    int up0, dw0, ld0;
    int hold_left[3];
    int gap_left[3];

    initial begin
        reset = 1'b1;
        frame = 1'b0; run = 1'b0; speed = '0;
        btn_inc = 1'b0; btn_dec = 1'b0; btn_ld = 1'b0;
        at_max = 1'b0; at_min = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_up", int'(UP), 0);
        check("rst_dw", int'(DW), 0);
        check("rst_ld", int'(LD), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_dir", int'(dir), int'(TB_DEF_DIR));
        reset = 1'b0;
        repeat (5) tick();

        // Start moving up at speed 0: one UP per frame.
        run = 1'b1; speed = '0;
        press(0, 2);
        repeat (3) tick();
        check("inc_moving", int'(moving), 1);
        check("inc_dir", int'(dir), 1);
        up0 = n_up; dw0 = n_dw; ld0 = n_ld;
        repeat (5) frame_pulse(2);
        check("speed0_up_count", n_up - up0, 5);
        check("speed0_dw_ld_count", (n_dw - dw0) + (n_ld - ld0), 0);

        // Speed 2: every 4th frame; then drop to speed 0 with two frames counted.
        speed = SW'(2);
        up0 = n_up;
        repeat (8) frame_pulse(2);
        check("speed2_up_count", n_up - up0, 2);
        up0 = n_up;
        repeat (2) frame_pulse(2);
        check("speed2_partial", n_up - up0, 0);
        speed = '0;
        frame_pulse(2);
        check("speed_drop_up", n_up - up0, 1);

        // Upper limit reached.
        at_max = 1'b1;
        up0 = n_up; dw0 = n_dw;
        frame_pulse(2);
        check("limit_no_step", (n_up - up0) + (n_dw - dw0), 0);
`ifdef VLINE_AUTO_BOUNCE_EN
        frame_pulse(2);
        check("bounce_dw", n_dw - dw0, 1);
        check("bounce_moving", int'(moving), 1);
        check("bounce_dir", int'(dir), 0);
`else
        check("hold_moving", int'(moving), 0);
        press(0, 2);
        repeat (3) tick();
        check("hold_inc_ignored", int'(moving), 0);
        press(1, 2);
        repeat (3) tick();
        check("hold_dec_moving", int'(moving), 1);
        check("hold_dec_dir", int'(dir), 0);
        frame_pulse(2);
        check("hold_resume_dw", n_dw - dw0, 1);
`endif
        at_max = 1'b0;

        // Load press whose event lands on a qualifying frame.
        up0 = n_up; dw0 = n_dw; ld0 = n_ld;
        set_btn(2, 1'b1);
        tick(); tick();
        btn_ld = 1'b0;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick(); tick();
        check("ld_count", n_ld - ld0, 1);
        check("ld_no_step", (n_up - up0) + (n_dw - dw0), 0);
        check("ld_idle", int'(moving), 0);

        // Simultaneous inc and dec from IDLE.
        up0 = n_up; dw0 = n_dw; ld0 = n_ld;
        set_btn(0, 1'b1);
        set_btn(1, 1'b1);
        tick(); tick();
        btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (3) tick();
        repeat (2) frame_pulse(2);
        check("both_idle", int'(moving), 0);
        check("both_dir", int'(dir), 0);
        check("both_no_strobe", (n_up - up0) + (n_dw - dw0) + (n_ld - ld0), 0);

        // Randomised traffic.
        for (int b = 0; b < 3; b++) begin
            hold_left[b] = 0;
            gap_left[b]  = 2;
        end
        for (int n = 0; n < 4000; n++) begin
            frame = ($urandom % 4 == 0);
            if (run ? ($urandom % 150 == 0) : ($urandom % 20 == 0)) run = ~run;
            if ($urandom % 50 == 0) speed = SW'($urandom_range(0, 3));
            if (at_max ? ($urandom % 15 == 0) : ($urandom % 100 == 0)) at_max = ~at_max;
            if (at_min ? ($urandom % 15 == 0) : ($urandom % 100 == 0)) at_min = ~at_min;
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] > 0) begin
                    hold_left[b]--;
                    if (hold_left[b] == 0) begin
                        case (b)
                            0: btn_inc = 1'b0;
                            1: btn_dec = 1'b0;
                            default: btn_ld = 1'b0;
                        endcase
                        gap_left[b] = 2 + int'($urandom_range(0, 4));
                    end
                end else if (gap_left[b] > 0) begin
                    gap_left[b]--;
                end else if ($urandom % 20 == 0) begin
                    set_btn(b, 1'b1);
                    hold_left[b] = 1 + int'($urandom_range(0, 3));
                end
            end
            tick();
        end
        frame = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_ld = 1'b0;
        repeat (6) tick();
        check("random_drained", exp_q.size(), 0);

        // Reset during an UP strobe while a button is held across reset release.
        at_max = 1'b0; at_min = 1'b0; run = 1'b1; speed = '0;
        press(2, 2);
        repeat (3) tick();
        press(0, 2);
        repeat (3) tick();
        set_btn(0, 1'b1);
        tick(); tick();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check("pre_reset_up", int'(UP), 1);
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_up_drop", int'(UP), 0);
        check("reset_dw", int'(DW), 0);
        check("reset_ld", int'(LD), 0);
        check("reset_moving", int'(moving), 0);
        check("reset_dir", int'(dir), int'(TB_DEF_DIR));
        tick(); tick();
        reset = 1'b0;
        up0 = n_up; dw0 = n_dw; ld0 = n_ld;
        repeat (6) tick();
        btn_inc = 1'b0;
        repeat (4) tick();
        check("held_no_event", int'(moving), 0);
        check("held_no_strobe", (n_up - up0) + (n_dw - dw0) + (n_ld - ld0), 0);
        press(0, 2);
        repeat (3) tick();
        check("repress_moving", int'(moving), 1);
        check("repress_dir", int'(dir), 1);
        repeat (3) tick();
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
